// File: rtl/qcore_ctrl_pipe.sv
// rtl/qcore_ctrl_pipe.sv - qcore pipeline-control sequencer for RD/X1/X2/WR register-write descriptors
// Descriptor layout is {addr[6:0], we, src[1:0]}; an all-zero descriptor is a bubble.
module qcore_ctrl_pipe #(
  parameter int CNT_W     = 8,
  parameter int STALL_MAX = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_vld_i,
  input  logic [9:0]       id_reg_i,
  input  logic             id_flag_we_i,
  input  logic             bubble_id_i,
  input  logic             bubble_rd_i,
  input  logic             flush_i,
  input  logic             halt_i,
  input  logic             stall_clr_i,
  output logic [9:0]       rd_reg_o,
  output logic [9:0]       x1_reg_o,
  output logic [9:0]       x2_reg_o,
  output logic [9:0]       wr_reg_o,
  output logic             flag_we_o,
  output logic             en_id_o,
  output logic             en_rd_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             stall_to_o
);

  localparam logic [CNT_W-1:0] STALL_MAX_V = CNT_W'(STALL_MAX);

  logic             rd_flag_q;
  logic             x1_flag_q;
  logic             x2_flag_q;
  logic             bub_req;
  logic             rd_kill;
  logic             x1_kill;
  logic             set_to;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    en_id_o = 1'b0;
    en_rd_o = 1'b0;
    if (!rst_i && !halt_i) begin
      en_id_o = flush_i | ~(bubble_rd_i | bubble_id_i);
      en_rd_o = flush_i | ~bubble_rd_i;
    end
  end

  // A flush outranks both bubble requests; bubble_rd freezes RD, everything else refills it.
  assign bub_req = bubble_id_i | bubble_rd_i;
  assign x1_kill = flush_i | bubble_rd_i;
  assign rd_kill = flush_i | (~bubble_rd_i & (bubble_id_i | ~id_vld_i));
  assign cnt_inc = (&stall_cnt_o) ? stall_cnt_o : stall_cnt_o + 1'b1;
  assign set_to  = ~halt_i & bub_req & (cnt_inc == STALL_MAX_V);

  assign flag_we_o = rd_flag_q | x1_flag_q | x2_flag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_reg_o    <= '0;
      x1_reg_o    <= '0;
      x2_reg_o    <= '0;
      wr_reg_o    <= '0;
      rd_flag_q   <= 1'b0;
      x1_flag_q   <= 1'b0;
      x2_flag_q   <= 1'b0;
      stall_cnt_o <= '0;
      stall_to_o  <= 1'b0;
    end else begin
      if (!halt_i) begin
        wr_reg_o  <= x2_reg_o;
        x2_reg_o  <= x1_reg_o;
        x2_flag_q <= x1_flag_q;
        if (x1_kill) begin
          x1_reg_o  <= '0;
          x1_flag_q <= 1'b0;
        end else begin
          x1_reg_o  <= rd_reg_o;
          x1_flag_q <= rd_flag_q;
        end
        if (rd_kill) begin
          rd_reg_o  <= '0;
          rd_flag_q <= 1'b0;
        end else if (!bubble_rd_i) begin
          rd_reg_o  <= id_reg_i;
          rd_flag_q <= id_flag_we_i;
        end
        stall_cnt_o <= bub_req ? cnt_inc : '0;
      end
      if (set_to) begin
        stall_to_o <= 1'b1;
      end else if (stall_clr_i) begin
        stall_to_o <= 1'b0;
      end
    end
  end

endmodule
